// File: rtl/async_fifo_pkg.sv
// Shared constants and sizing helpers for the async FIFO read-side blocks.
package async_fifo_pkg;

  localparam int DSIZE_DEFAULT       = 8;
  localparam int MIN_BUF_DEPTH       = 2;
  localparam int FULL_RATE_BUF_DEPTH = 3;

  // Occupancy must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Circular output buffer: push captures FIFO read data at the tail, pop retires the head.
module fifo_rd_obuf
  import async_fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEFAULT,
  parameter int BUF_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [DSIZE-1:0]                push_data,
  input  logic                            pop,
  output logic [DSIZE-1:0]                head_data,
  output logic [occ_width(BUF_DEPTH)-1:0] occ,
  output logic                            not_empty
);

  localparam int OCC_W = occ_width(BUF_DEPTH);
  localparam int PTR_W = ptr_width(BUF_DEPTH);

  logic [DSIZE-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_pop;

  // Pointers wrap at BUF_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && (occ != '0);
  assign not_empty = (occ != '0);
  assign head_data = buf_mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (do_pop) head <= ptr_inc(head);
      if (push && !do_pop) begin
        occ <= occ + OCC_W'(1);
      end else if (!push && do_pop) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[tail] <= push_data;
  end

  occ_le_depth: assert property (@(posedge clk) disable iff (rst) occ <= OCC_W'(BUF_DEPTH));

endmodule

// File: rtl/async_fifo_rd_stream.sv
// FIFO read-side consumer: credit-based rinc, one-cycle read latency absorbed by an
// output buffer, delivered as a full-rate valid/ready stream.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEFAULT,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                            rclk,
  input  logic                            rrst,
  input  logic                            rempty,
  input  logic [DSIZE-1:0]                rdata,
  output logic                            rinc,
  output logic                            m_valid,
  output logic [DSIZE-1:0]                m_data,
  input  logic                            m_ready,
  output logic [occ_width(BUF_DEPTH)-1:0] occ,
  output logic [CNT_W-1:0]                words_out
);

  localparam int OCC_W = occ_width(BUF_DEPTH);
  localparam logic [OCC_W:0] CREDIT_MAX = (OCC_W + 1)'(BUF_DEPTH - 1);

  if (BUF_DEPTH < MIN_BUF_DEPTH) begin : g_depth_check
    $error("async_fifo_rd_stream: BUF_DEPTH must be at least %0d", MIN_BUF_DEPTH);
  end

  logic           inflight;
  logic           beat;
  logic [OCC_W:0] credit_used;

  // A word already requested still needs a slot, so it counts against the credit.
  assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign rinc        = !rrst && !rempty && (credit_used <= CREDIT_MAX);
  assign beat        = m_valid && m_ready;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight  <= 1'b0;
      words_out <= '0;
    end else begin
      inflight <= rinc;
      if (beat) words_out <= words_out + CNT_W'(1);
    end
  end

  fifo_rd_obuf #(
    .DSIZE    (DSIZE),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_obuf (
    .clk      (rclk),
    .rst      (rrst),
    .push     (inflight),
    .push_data(rdata),
    .pop      (beat),
    .head_data(m_data),
    .occ      (occ),
    .not_empty(m_valid)
  );

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT, a negedge monitor checks beats.
module tb_async_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [2:0]  occ;
  logic [15:0] words_out;

  logic        rinc4;
  logic        m_valid4;
  logic [7:0]  m_data4;
  logic [2:0]  occ4;
  logic [3:0]  words_out4;

  int total = 0;
  int bad = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int   words_written = 0;
  bit   gap = 1'b0;
  bit   rinc_seen = 1'b0;
  int   rinc_count = 0;
  bit   hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always #5 rclk = ~rclk;

  async_fifo_rd_stream #(.DSIZE(8), .BUF_DEPTH(4), .CNT_W(16)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .occ(occ),
    .words_out(words_out)
  );

  async_fifo_rd_stream #(.DSIZE(8), .BUF_DEPTH(4), .CNT_W(4)) dut4 (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
    .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready), .occ(occ4),
    .words_out(words_out4)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One read-clock cycle of the FIFO model: a request seen last cycle pops the queue.
  task automatic applyStimulus();
    @(posedge rclk);
    #1;
    if (rinc_seen && fifo_q.size() > 0) rdata = fifo_q.pop_front();
    rempty = (fifo_q.size() == 0) || gap;
    #1;
  endtask

  task automatic writeWord(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    words_written++;
  endtask

  task automatic doReset();
    rrst = 1'b1;
    #1;
    checkOutput("rinc_in_reset", 32'(rinc), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    words_written = 0;
    applyStimulus();
    rrst = 1'b0;
    checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_occ", 32'(occ), 32'd0);
    checkOutput("reset_words_out", 32'(words_out), 32'd0);
  endtask

  task automatic drainAll(input string name);
    int n;
    m_ready = 1'b1;
    gap = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      applyStimulus();
      n++;
    end
    applyStimulus();
    applyStimulus();
    checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    checkOutput({name, "_m_valid_low"}, 32'(m_valid), 32'd0);
    checkOutput({name, "_words_out"}, 32'(words_out), 32'(words_written & 16'hFFFF));
  endtask

  // Monitor: scoreboard pops on every accepted beat, plus per-cycle invariants.
  always @(negedge rclk) begin
    rinc_seen = rinc;
    if (rinc) rinc_count++;
    if (rrst) begin
      hold_pending = 1'b0;
    end else begin
      checkOutput("rinc_while_empty", 32'(rinc & rempty), 32'd0);
      checkOutput("occ_le_4", 32'(occ <= 3'd4), 32'd1);
      if (hold_pending)
        checkOutput("hold_stable", {23'd0, m_valid, m_data}, {23'd0, 1'b1, hold_data});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL stream_extra_beat: got 0x%0h, expected no beat", m_data);
        end else begin
          checkOutput("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      hold_pending = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  initial begin
    logic [7:0] first3 [3];
    int n;
    int run;
    int cnt;
    first3[0] = 8'h11;
    first3[1] = 8'h22;
    first3[2] = 8'h33;
    rrst = 1'b1;
    rempty = 1'b1;
    rdata = 8'h00;
    m_ready = 1'b0;
    applyStimulus();
    doReset();

    $display("[TB] latency and first words");
    m_ready = 1'b1;
    gap = 1'b1;
    for (int i = 0; i < 3; i++) writeWord(first3[i]);
    applyStimulus();
    gap = 1'b0;
    applyStimulus();
    checkOutput("lat_rinc_t", 32'(rinc), 32'd1);
    checkOutput("lat_valid_t", 32'(m_valid), 32'd0);
    applyStimulus();
    checkOutput("lat_valid_t1", 32'(m_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("lat_valid_beat", 32'(m_valid), 32'd1);
      checkOutput("lat_data_beat", 32'(m_data), 32'(first3[i]));
    end
    applyStimulus();
    checkOutput("lat_valid_after", 32'(m_valid), 32'd0);
    checkOutput("lat_words_out", 32'(words_out), 32'd3);

    $display("[TB] 64-word full-rate stream");
    gap = 1'b1;
    for (int i = 0; i < 64; i++) writeWord(8'(i));
    applyStimulus();
    gap = 1'b0;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!m_valid && n < 10);
    checkOutput("rate_start", 32'(m_valid), 32'd1);
    run = 0;
    while (m_valid && run < 100) begin
      run++;
      applyStimulus();
    end
    checkOutput("rate_run_len", 32'(run), 32'd64);
    checkOutput("rate_words_out", 32'(words_out), 32'(words_written));

    $display("[TB] backpressure fill");
    m_ready = 1'b0;
    gap = 1'b1;
    for (int i = 0; i < 10; i++) writeWord(8'(i));
    applyStimulus();
    gap = 1'b0;
    rinc_count = 0;
    repeat (15) applyStimulus();
    checkOutput("bp_rinc_pulses", 32'(rinc_count), 32'd4);
    checkOutput("bp_occ", 32'(occ), 32'd4);
    checkOutput("bp_m_valid", 32'(m_valid), 32'd1);
    checkOutput("bp_m_data", 32'(m_data), 32'h00);
    drainAll("bp");

    $display("[TB] random traffic");
    cnt = 0;
    n = 0;
    while ((cnt < 1000 || fifo_q.size() != 0) && n < 20000) begin
      if (cnt < 1000 && $urandom_range(0, 3) != 0) begin
        writeWord(8'($urandom_range(0, 255)));
        cnt++;
      end
      gap = ($urandom_range(0, 4) == 0);
      m_ready = 1'($urandom_range(0, 1));
      applyStimulus();
      n++;
    end
    checkOutput("rand_all_written", 32'(cnt), 32'd1000);
    drainAll("rand");

    $display("[TB] mid-stream reset");
    m_ready = 1'b0;
    gap = 1'b1;
    for (int i = 0; i < 10; i++) writeWord(8'(8'hB0 + i));
    applyStimulus();
    gap = 1'b0;
    n = 0;
    while (occ != 3'd3 && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput("pre_reset_occ", 32'(occ), 32'd3);
    doReset();
    writeWord(8'hA0);
    writeWord(8'hA1);
    drainAll("post_reset");

    $display("[TB] counter wrap");
    doReset();
    for (int i = 0; i < 17; i++) writeWord(8'(8'h40 + i));
    drainAll("wrap");
    checkOutput("wrap_words_out4", 32'(words_out4), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
